// File: rtl/cmp_chk_pkg.sv
// Shared types and golden model for the magnitude-comparator response checker.
package cmp_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   localparam int CMP_N    = 2;
   localparam int COV_SIZE = 1 << (2 * CMP_N);

   // Golden response {gt, eq, lt}; operands are zero-extended, so the compare is unsigned.
   function automatic logic [2:0] cmp_expected(input logic [31:0] opa, input logic [31:0] opb);
      return {opa > opb, opa == opb, opa < opb};
   endfunction

endpackage

// File: rtl/cmp_chk_delay.sv
// LAT-stage shift pipeline carrying {vld, data}; LAT=0 is a pure passthrough.
module cmp_chk_delay #(
   parameter int LAT = 1,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   output logic         vld_o,
   output logic [W-1:0] data_o,
   output logic         pend_o
);

   generate
      if (LAT == 0) begin : g_pass
         logic unused_s;
         assign unused_s = clk ^ rst ^ clr_i;
         assign vld_o    = vld_i;
         assign data_o   = data_i;
         assign pend_o   = 1'b0;
      end else begin : g_pipe
         logic [LAT-1:0] vld_q;
         logic [W-1:0]   data_q [LAT];
         logic [LAT:0]   chain_s;

         // chain_s[0] is the entry arriving now; pend_o flags anything still in flight after this edge
         assign chain_s = {vld_q, vld_i};

         always_ff @(posedge clk) begin
            if (rst || clr_i) begin
               vld_q <= {LAT{1'b0}};
               for (int i = 0; i < LAT; i++) begin
                  data_q[i] <= {W{1'b0}};
               end
            end else begin
               vld_q     <= chain_s[LAT-1:0];
               data_q[0] <= data_i;
               for (int i = 1; i < LAT; i++) begin
                  data_q[i] <= data_q[i-1];
               end
            end
         end

         assign vld_o  = vld_q[LAT-1];
         assign data_o = data_q[LAT-1];
         assign pend_o = |chain_s[LAT-1:0];
      end
   endgenerate

endmodule

// File: rtl/comparator_response_checker.sv
// Checks a 2N-bit magnitude comparator's gt/eq/lt against a golden model and tracks pair coverage.
// Optional idle timeout enabled by defining CMP_CHECK_TIMEOUT_EN.
module comparator_response_checker
   import cmp_chk_pkg::*;
#(
   parameter int N       = CMP_N,
   parameter int LAT     = 1,
   parameter int ERR_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [N-1:0]     opa,
   input  logic [N-1:0]     opb,
   input  logic             gt,
   input  logic             eq,
   input  logic             lt,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] cov_cnt,
   output logic [2*N-1:0]   first_err
);

   localparam int PW  = 2 * N;
   localparam int COV = (N == CMP_N) ? COV_SIZE : (1 << PW);

   cmp_state_e       state_q;
   logic [COV-1:0]   bitmap_q, bitmap_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d, cov_cnt_q, cov_cnt_d;
   logic [PW-1:0]    first_err_q;
   logic             busy_q, done_q, pass_q, err_pulse_q;

   logic             run_s, clr_s, d_vld_s, pend_s, chk_s, mis_s, new_s, fin_s, tmo_s;
   logic [PW-1:0]    d_pair_s;
   logic [2:0]       exp_s;

   assign run_s = (state_q == RUN);
   assign clr_s = start & ~run_s;

   cmp_chk_delay #(.LAT(LAT), .W(PW)) u_delay (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr_s),
      .vld_i  (in_valid & run_s),
      .data_i ({opa, opb}),
      .vld_o  (d_vld_s),
      .data_o (d_pair_s),
      .pend_o (pend_s)
   );

   // Check the matured sample and compute next statistics; fin_s uses post-update coverage
   always_comb begin
      exp_s     = cmp_expected(32'(d_pair_s[PW-1:N]), 32'(d_pair_s[N-1:0]));
      chk_s     = d_vld_s & run_s;
      mis_s     = chk_s & ({gt, eq, lt} != exp_s);
      bitmap_d  = bitmap_q;
      new_s     = 1'b0;
      if (chk_s) begin
         new_s              = ~bitmap_q[d_pair_s];
         bitmap_d[d_pair_s] = 1'b1;
      end else begin
         new_s = 1'b0;
      end
      if (mis_s && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_d = err_cnt_q;
      end
      if (new_s) begin
         cov_cnt_d = cov_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
         cov_cnt_d = cov_cnt_q;
      end
      fin_s = (&bitmap_d) & ~pend_s;
   end

`ifdef CMP_CHECK_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_q;

   assign tmo_s = run_s & ~in_valid & (idle_q == IW'(TIMEOUT - 1));

   // Idle-cycle counter, live only in RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= {IW{1'b0}};
      end else if (!run_s || in_valid) begin
         idle_q <= {IW{1'b0}};
      end else begin
         idle_q <= idle_q + {{(IW-1){1'b0}}, 1'b1};
      end
   end
`else
   logic [31:0] unused_tmo_s;
   assign unused_tmo_s = 32'(TIMEOUT);
   assign tmo_s        = 1'b0;
`endif

   // Run-control FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         bitmap_q    <= {COV{1'b0}};
         err_cnt_q   <= {ERR_W{1'b0}};
         cov_cnt_q   <= {ERR_W{1'b0}};
         first_err_q <= {PW{1'b0}};
      end else begin
         case (state_q)
            IDLE, DONE: begin
               err_pulse_q <= 1'b0;
               if (start) begin
                  state_q     <= RUN;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  bitmap_q    <= {COV{1'b0}};
                  err_cnt_q   <= {ERR_W{1'b0}};
                  cov_cnt_q   <= {ERR_W{1'b0}};
                  first_err_q <= {PW{1'b0}};
               end
            end
            RUN: begin
               err_pulse_q <= mis_s;
               bitmap_q    <= bitmap_d;
               err_cnt_q   <= err_cnt_d;
               cov_cnt_q   <= cov_cnt_d;
               if (mis_s && (err_cnt_q == {ERR_W{1'b0}})) begin
                  first_err_q <= d_pair_s;
               end
               if (fin_s || tmo_s) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_cnt_d == {ERR_W{1'b0}}) & ~tmo_s;
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               pass_q      <= 1'b0;
               err_pulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign cov_cnt   = cov_cnt_q;
   assign first_err = first_err_q;

endmodule

// File: tb/tb_comparator_response_checker.sv
// Self-checking bench: queue-based reference model compared every cycle, plus hand-computed end-of-test values.
module tb_comparator_response_checker;

   localparam int LAT = 1;
   localparam int TMO = 8;

   logic       clk, rst, start, in_valid, gt, eq, lt;
   logic [1:0] opa, opb;
   logic       busy, done, pass, err_pulse;
   logic [7:0] err_cnt, cov_cnt;
   logic [3:0] first_err;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_cnt = 0;
   bit cmp_en = 1'b0;

   int         resp_mode = 0;
   bit         ovr_en = 1'b0;
   logic [3:0] ovr_pair = 4'd0;
   logic [2:0] ovr_val = 3'd0;

   comparator_response_checker #(.N(2), .LAT(LAT), .ERR_W(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .opa(opa), .opb(opb), .gt(gt), .eq(eq), .lt(lt),
      .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .cov_cnt(cov_cnt), .first_err(first_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Comparator response the bench presents, optionally faulted
   function automatic logic [2:0] resp(input logic [3:0] p);
      logic [1:0] a, b;
      logic [2:0] r;
      a = p[3:2];
      b = p[1:0];
      r = {a > b, a == b, a < b};
      if (resp_mode == 1) r[1] = 1'b0;
      if (ovr_en && p == ovr_pair) r = ovr_val;
      return r;
   endfunction

   // ---------------- reference model ----------------
   int          m_state = 0;      // 0 idle, 1 run, 2 done
   bit          m_seen[16];
   int          m_err = 0, m_cov = 0, m_first = 0, m_idle = 0;
   bit          m_pulse = 1'b0, m_pass = 1'b0;
   int unsigned q_pair[$];
   int unsigned q_due[$];
   int unsigned ecount = 0;

   task automatic m_clear();
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      m_err = 0; m_cov = 0; m_first = 0; m_idle = 0;
      m_pulse = 1'b0; m_pass = 1'b0;
      q_pair.delete(); q_due.delete();
   endtask

   always @(posedge clk) begin
      int unsigned p;
      int a, b;
      bit tmo;
      ecount++;
      m_pulse = 1'b0;
      if (rst) begin
         m_clear();
         m_state = 0;
      end else if (m_state != 1) begin
         if (start) begin
            m_clear();
            m_state = 1;
         end
      end else begin
         if (in_valid) begin
            q_pair.push_back(32'({opa, opb}));
            q_due.push_back(ecount + LAT);
         end
         if (q_due.size() > 0 && q_due[0] == ecount) begin
            p = q_pair.pop_front();
            void'(q_due.pop_front());
            a = int'(p / 4);
            b = int'(p % 4);
            if ({gt, eq, lt} != {a > b, a == b, a < b}) begin
               if (m_err == 0) m_first = int'(p);
               if (m_err < 255) m_err++;
               m_pulse = 1'b1;
            end
            if (!m_seen[p]) begin
               m_seen[p] = 1'b1;
               m_cov++;
            end
         end
         tmo = 1'b0;
`ifdef CMP_CHECK_TIMEOUT_EN
         m_idle = in_valid ? 0 : m_idle + 1;
         tmo = (m_idle == TMO);
`endif
         if ((m_cov == 16 && q_pair.size() == 0) || tmo) begin
            m_state = 2;
            m_pass = (m_err == 0) && !tmo;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", 32'(busy), 32'(m_state == 1));
         check("done", 32'(done), 32'(m_state == 2));
         check("pass", 32'(pass), 32'(m_pass));
         check("err_pulse", 32'(err_pulse), 32'(m_pulse));
         check("err_cnt", 32'(err_cnt), 32'(m_err));
         check("cov_cnt", 32'(cov_cnt), 32'(m_cov));
         check("first_err", 32'(first_err), 32'(m_first));
         if (err_pulse) pulse_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      logic       v;
      logic [3:0] p;
      v = in_valid;
      p = {opa, opb};
      @(posedge clk);
      #1;
      if (v) {gt, eq, lt} = resp(p);
      else   {gt, eq, lt} = 3'b000;
   endtask

   task automatic run_pair(input int p);
      in_valid = 1'b1;
      opa = 2'(p >> 2);
      opb = 2'(p);
      tick();
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int p = lo; p <= hi; p++) run_pair(p);
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      pulse_cnt = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      opa = 2'd0; opb = 2'd0; gt = 1'b0; eq = 1'b0; lt = 1'b0;
      tick(); tick();
      rst = 1'b0;
      cmp_en = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_cov", 32'(cov_cnt), 32'd0);
      check("rst_first", 32'(first_err), 32'd0);
      tick();

      // Exhaustive, correct responses
      do_start();
      check("t1_busy", 32'(busy), 32'd1);
      run_range(0, 15);
      check("t1_done_early", 32'(done), 32'd0);
      tick();
      check("t1_done", 32'(done), 32'd1);
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_err", 32'(err_cnt), 32'd0);
      check("t1_cov", 32'(cov_cnt), 32'd16);
      check("t1_first", 32'(first_err), 32'd0);
      check("t1_model_cov", 32'(m_cov), 32'd16);

      // Stuck eq
      resp_mode = 1;
      do_start();
      run_range(0, 15);
      tick(); tick();
      check("t2_done", 32'(done), 32'd1);
      check("t2_err", 32'(err_cnt), 32'd4);
      check("t2_first", 32'(first_err), 32'd0);
      check("t2_pass", 32'(pass), 32'd0);
      check("t2_pulses", 32'(pulse_cnt), 32'd4);
      check("t2_model_err", 32'(m_err), 32'd4);
      resp_mode = 0;

      // Duplicates are checked but counted once
      do_start();
      for (int k = 0; k < 5; k++) run_pair(6);
      run_range(0, 15);
      check("t3_done_early", 32'(done), 32'd0);
      tick();
      check("t3_done", 32'(done), 32'd1);
      check("t3_cov", 32'(cov_cnt), 32'd16);
      check("t3_pass", 32'(pass), 32'd1);

      // Non-one-hot response on pair {10,01}
      ovr_en = 1'b1; ovr_pair = 4'b1001; ovr_val = 3'b110;
      do_start();
      run_range(0, 15);
      tick(); tick();
      check("t4_err", 32'(err_cnt), 32'd1);
      check("t4_first", 32'(first_err), 32'd9);
      check("t4_pass", 32'(pass), 32'd0);
      check("t4_pulses", 32'(pulse_cnt), 32'd1);
      ovr_en = 1'b0;

      // Reset mid-run aborts, fresh run needs all pairs
      do_start();
      run_range(0, 6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_cov", 32'(cov_cnt), 32'd0);
      check("t5_err", 32'(err_cnt), 32'd0);
      check("t5_pulse", 32'(err_pulse), 32'd0);
      do_start();
      run_range(7, 15);
      tick(); tick();
      check("t5_not_done", 32'(done), 32'd0);
      check("t5_cov9", 32'(cov_cnt), 32'd9);
      run_range(0, 6);
      tick();
      check("t5_done", 32'(done), 32'd1);
      check("t5_pass", 32'(pass), 32'd1);

`ifdef CMP_CHECK_TIMEOUT_EN
      // Idle timeout after three pairs
      do_start();
      run_range(0, 2);
      repeat (TMO - 1) tick();
      check("t6_done_early", 32'(done), 32'd0);
      tick();
      check("t6_done", 32'(done), 32'd1);
      check("t6_pass", 32'(pass), 32'd0);
      check("t6_cov", 32'(cov_cnt), 32'd3);
      check("t6_err", 32'(err_cnt), 32'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
